calc_port_responder: RTL and testbench

Single-port behavioural responder for the calculator request/response protocol. Accepts two-cycle requests (command, tag and operand 1, then operand 2), queues them, executes add/subtract/shift, and returns one tagged response per request. It stands in for one DUT port so driver, monitor and scoreboard can be brought up and cross-checked without the real calculator.

---
 rtl/calc_rsp_pkg.sv | 33 +++
 rtl/calc_rsp_fifo.sv | 89 ++++++++
 rtl/calc_port_responder.sv | 219 +++++++++++++++++++++
 tb/tb_calc_port_responder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_rsp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : calc_rsp_pkg                                               |
// | Description : Shared command/response encodings and the queued request  |
// |               record for the calculator port responder.                  |
// | Ports       : none (package)                                             |
// | Options     : CALC_RSP_SHIFT_EN enables the shift commands in the top.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package calc_rsp_pkg;

   // Command encodings carried on req_cmd_in (bit 0 is the MSB).
   localparam logic [0:3] CMD_NOP = 4'd0;
   localparam logic [0:3] CMD_ADD = 4'd1;
   localparam logic [0:3] CMD_SUB = 4'd2;
   localparam logic [0:3] CMD_SHL = 4'd5;
   localparam logic [0:3] CMD_SHR = 4'd6;

   // Response encodings driven on out_resp; code 3 is never produced.
   localparam logic [0:1] RSP_NONE = 2'd0;
   localparam logic [0:1] RSP_OK   = 2'd1;
   localparam logic [0:1] RSP_ERR  = 2'd2;

   // One fully assembled request as held in the queue.
   typedef struct packed {
      logic [0:3]  cmd;
      logic [0:1]  tag;
      logic [0:31] op1;
      logic [0:31] op2;
   } calc_req_t;

endpackage
`default_nettype wire

// File: rtl/calc_rsp_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : calc_rsp_fifo                                              |
// | Description : DEPTH-entry synchronous FIFO of calc_req_t with            |
// |               wrap-around pointers and a DEPTH+1-state occupancy count.  |
// |               A push while full is ignored unless a pop happens in the   |
// |               same cycle, in which case the freed slot takes it.         |
// | Ports       : clk        in  clock, rising edge                          |
// |               rst_n      in  synchronous reset, active low               |
// |               push       in  write push_data this cycle                  |
// |               push_data  in  entry to write                              |
// |               pop        in  retire the head entry this cycle            |
// |               full       out DEPTH entries held                          |
// |               empty      out no entries held                             |
// |               head       out oldest entry (valid when !empty)            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module calc_rsp_fifo
   import calc_rsp_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push,
   input  calc_req_t push_data,
   input  logic      pop,
   output logic      full,
   output logic      empty,
   output calc_req_t head
);

   localparam int               PTR_W    = $clog2(DEPTH);
   localparam int               CNT_W    = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   calc_req_t        mem_q [DEPTH];
   calc_req_t        mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             wr_en;
   logic             rd_en;

   assign full  = (count_q == CNT_FULL);
   assign empty = (count_q == '0);
   assign head  = mem_q[rd_ptr_q];

   always_comb begin
      rd_en    = pop && !empty;
      // A pop in the same cycle frees the slot a full queue would refuse.
      wr_en    = push && (!full || rd_en);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;   // power-of-two depth wraps naturally
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the count alone decides what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule
`default_nettype wire

// File: rtl/calc_port_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : calc_port_responder                                        |
// | Description : Behavioural stand-in for one calculator port. Captures     |
// |               two-cycle requests, queues them, executes add/sub/shift    |
// |               and returns one tagged response per accepted request, in   |
// |               queue order, LATENCY cycles after each pop.                |
// | Parameters  : DEPTH   request queue entries (power of two, >= 2)         |
// |               LATENCY cycles from queue pop to response (>= 1)           |
// | Ports       : c_clk        in  sole clock, rising edge                   |
// |               reset        in  synchronous reset, active low             |
// |               req_cmd_in   in  [0:3]  command, 0 = no request            |
// |               req_tag_in   in  [0:1]  request tag                        |
// |               req_data_in  in  [0:31] operand 1, then operand 2          |
// |               out_resp     out [0:1]  0 none, 1 ok, 2 error              |
// |               out_data     out [0:31] result, 0 unless out_resp = 1      |
// |               out_tag      out [0:1]  tag of the answered request        |
// |               drop_cnt     out [0:7]  requests lost to a full queue      |
// | Options     : CALC_RSP_SHIFT_EN - build the shifter for commands 5/6;    |
// |               without it those commands answer with an error.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module calc_port_responder
   import calc_rsp_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int LATENCY = 3
) (
   input  logic        c_clk,
   input  logic        reset,
   input  logic [0:3]  req_cmd_in,
   input  logic [0:1]  req_tag_in,
   input  logic [0:31] req_data_in,
   output logic [0:1]  out_resp,
   output logic [0:31] out_data,
   output logic [0:1]  out_tag,
   output logic [0:7]  drop_cnt
);

   // BUSY counts 0 .. LATENCY-2; with LATENCY = 1 the executor skips BUSY.
   localparam int              WAIT_W    = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((LATENCY > 2) ? (LATENCY - 2) : 0);

   typedef enum logic [0:0] {
      CAP_CMD = 1'b0,
      CAP_OP2 = 1'b1
   } cap_state_t;

   typedef enum logic [0:1] {
      EXE_IDLE = 2'd0,
      EXE_BUSY = 2'd1,
      EXE_RESP = 2'd2
   } exe_state_t;

   cap_state_t        cap_state_q, cap_state_d;
   logic [0:3]        cmd_q, cmd_d;
   logic [0:1]        tag_q, tag_d;
   logic [0:31]       op1_q, op1_d;
   exe_state_t        exe_state_q, exe_state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   calc_req_t         cur_q, cur_d;
   logic [0:7]        drop_cnt_q, drop_cnt_d;

   calc_req_t         push_entry;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   calc_req_t         fifo_head;

   logic [0:1]        alu_rsp;
   logic [0:31]       alu_data;
   logic [0:32]       alu_sum;

   // ---------------------------------------------------------------- capture
   always_comb begin
      cap_state_d    = cap_state_q;
      cmd_d          = cmd_q;
      tag_d          = tag_q;
      op1_d          = op1_q;
      fifo_push      = 1'b0;
      push_entry.cmd = cmd_q;
      push_entry.tag = tag_q;
      push_entry.op1 = op1_q;
      push_entry.op2 = req_data_in;
      case (cap_state_q)
         CAP_CMD: begin
            if (req_cmd_in != CMD_NOP) begin
               cmd_d       = req_cmd_in;
               tag_d       = req_tag_in;
               op1_d       = req_data_in;
               cap_state_d = CAP_OP2;
            end
         end
         CAP_OP2: begin
            // Operand 2 is taken whatever req_cmd_in says this cycle.
            fifo_push   = 1'b1;
            cap_state_d = CAP_CMD;
         end
         default: cap_state_d = CAP_CMD;
      endcase
   end

   // ------------------------------------------------------------------ queue
   calc_rsp_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (c_clk),
      .rst_n     (reset),
      .push      (fifo_push),
      .push_data (push_entry),
      .pop       (fifo_pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (fifo_head)
   );

   // A push is lost only when the queue is full and nothing leaves this cycle.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (fifo_push && fifo_full && !fifo_pop && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 1'b1;
      end
   end

   // --------------------------------------------------------------- executor
   always_comb begin
      exe_state_d = exe_state_q;
      wait_d      = wait_q;
      cur_d       = cur_q;
      fifo_pop    = 1'b0;
      case (exe_state_q)
         EXE_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop    = 1'b1;
               cur_d       = fifo_head;
               wait_d      = '0;
               exe_state_d = (LATENCY > 1) ? EXE_BUSY : EXE_RESP;
            end
         end
         EXE_BUSY: begin
            if (wait_q == WAIT_LAST) begin
               exe_state_d = EXE_RESP;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         EXE_RESP: exe_state_d = EXE_IDLE;
         default:  exe_state_d = EXE_IDLE;
      endcase
   end

   // -------------------------------------------------------------------- ALU
   always_comb begin
      alu_rsp  = RSP_ERR;
      alu_data = '0;
      alu_sum  = '0;
      case (cur_q.cmd)
         CMD_ADD: begin
            alu_sum = {1'b0, cur_q.op1} + {1'b0, cur_q.op2};
            if (!alu_sum[0]) begin        // bit 0 is the carry out
               alu_rsp  = RSP_OK;
               alu_data = alu_sum[1:32];
            end
         end
         CMD_SUB: begin
            if (cur_q.op1 >= cur_q.op2) begin
               alu_rsp  = RSP_OK;
               alu_data = cur_q.op1 - cur_q.op2;
            end
         end
`ifdef CALC_RSP_SHIFT_EN
         CMD_SHL: begin
            alu_rsp  = RSP_OK;
            alu_data = cur_q.op1 << cur_q.op2[27:31];
         end
         CMD_SHR: begin
            alu_rsp  = RSP_OK;
            alu_data = cur_q.op1 >> cur_q.op2[27:31];
         end
`endif
         default: begin
            alu_rsp  = RSP_ERR;
            alu_data = '0;
         end
      endcase
   end

   // Outputs are quiet except in the single RESP cycle.
   assign out_resp = (exe_state_q == EXE_RESP) ? alu_rsp : RSP_NONE;
   assign out_data = ((exe_state_q == EXE_RESP) && (alu_rsp == RSP_OK)) ? alu_data : '0;
   assign out_tag  = (exe_state_q == EXE_RESP) ? cur_q.tag : '0;
   assign drop_cnt = drop_cnt_q;

   // -------------------------------------------------------------- registers
   always_ff @(posedge c_clk) begin
      if (!reset) begin
         cap_state_q <= CAP_CMD;
         cmd_q       <= CMD_NOP;
         tag_q       <= '0;
         op1_q       <= '0;
         exe_state_q <= EXE_IDLE;
         wait_q      <= '0;
         cur_q       <= '0;
         drop_cnt_q  <= '0;
      end else begin
         cap_state_q <= cap_state_d;
         cmd_q       <= cmd_d;
         tag_q       <= tag_d;
         op1_q       <= op1_d;
         exe_state_q <= exe_state_d;
         wait_q      <= wait_d;
         cur_q       <= cur_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_calc_port_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_calc_port_responder                                     |
// | Description : Directed self-checking bench for calc_port_responder at    |
// |               default parameters. Expected values are hand computed.     |
// | Options     : CALC_RSP_SHIFT_EN selects the shift expectations.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_calc_port_responder;
   import calc_rsp_pkg::*;

`ifdef CALC_RSP_SHIFT_EN
   localparam bit SH_ON = 1'b1;
`else
   localparam bit SH_ON = 1'b0;
`endif

   logic        c_clk = 1'b0;
   logic        reset;
   logic [0:3]  req_cmd_in;
   logic [0:1]  req_tag_in;
   logic [0:31] req_data_in;
   logic [0:1]  out_resp;
   logic [0:31] out_data;
   logic [0:1]  out_tag;
   logic [0:7]  drop_cnt;

   calc_port_responder dut (
      .c_clk       (c_clk),
      .reset       (reset),
      .req_cmd_in  (req_cmd_in),
      .req_tag_in  (req_tag_in),
      .req_data_in (req_data_in),
      .out_resp    (out_resp),
      .out_data    (out_data),
      .out_tag     (out_tag),
      .drop_cnt    (drop_cnt)
   );

   always #5 c_clk = ~c_clk;

   int cyc = 0;
   always @(posedge c_clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
      end
   endtask

   // Response monitor, sampled on the falling edge.
   typedef struct {
      int          at;
      logic [0:1]  resp;
      logic [0:1]  tag;
      logic [0:31] data;
   } rsp_rec_t;

   rsp_rec_t rsp_q[$];
   int       quiet_bad = 0;

   always @(negedge c_clk) begin
      if (reset === 1'b1) begin
         if (out_resp != 2'd0) rsp_q.push_back('{cyc, out_resp, out_tag, out_data});
         else if ((out_data != 32'd0) || (out_tag != 2'd0)) quiet_bad++;
      end
   end

   // Drives one request starting now (just after a rising edge); n is its
   // command cycle. The OP2 cycle carries junk on cmd/tag, which must be ignored.
   task automatic send(input logic [0:3] cmd, input logic [0:1] tag,
                       input logic [0:31] op1, input logic [0:31] op2, output int n);
      req_cmd_in  = cmd;
      req_tag_in  = tag;
      req_data_in = op1;
      n           = cyc;
      @(posedge c_clk); #1;
      req_cmd_in  = 4'hA;
      req_tag_in  = ~tag;
      req_data_in = op2;
      @(posedge c_clk); #1;
      req_cmd_in  = CMD_NOP;
      req_tag_in  = 2'd0;
      req_data_in = 32'd0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge c_clk);
      #1;
   endtask

   task automatic expect_rsp(input string name, input int at, input logic [0:1] resp,
                             input logic [0:1] tag, input logic [0:31] data);
      rsp_rec_t r;
      for (int i = 0; i < 60 && rsp_q.size() == 0; i++) begin
         @(posedge c_clk); #1;
      end
      check_eq({name, " arrived"}, 32'(rsp_q.size() != 0), 32'd1);
      if (rsp_q.size() != 0) begin
         r = rsp_q.pop_front();
         check_eq({name, " cycle"}, r.at, at);
         check_eq({name, " resp"}, 32'(r.resp), 32'(resp));
         check_eq({name, " tag"}, 32'(r.tag), 32'(tag));
         check_eq({name, " data"}, r.data, data);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int n, n2;
   int s[10];

   initial begin
      reset       = 1'b0;
      req_cmd_in  = CMD_NOP;
      req_tag_in  = 2'd0;
      req_data_in = 32'd0;
      idle(3);
      check_eq("reset out_resp", 32'(out_resp), 32'd0);
      check_eq("reset out_data", out_data, 32'd0);
      check_eq("reset out_tag", 32'(out_tag), 32'd0);
      check_eq("reset drop_cnt", 32'(drop_cnt), 32'd0);
      reset = 1'b1;
      idle(1);

      // Basic add, response at N+5.
      send(CMD_ADD, 2'd2, 32'h0000_0005, 32'h0000_0007, n);
      expect_rsp("add", n + 5, RSP_OK, 2'd2, 32'h0000_000C);

      // Overflow / underflow.
      send(CMD_ADD, 2'd1, 32'hFFFF_FFFF, 32'h0000_0001, n);
      expect_rsp("add ovf", n + 5, RSP_ERR, 2'd1, 32'd0);
      send(CMD_SUB, 2'd0, 32'd3, 32'd4, n);
      expect_rsp("sub unf", n + 5, RSP_ERR, 2'd0, 32'd0);
      send(CMD_SUB, 2'd3, 32'd4, 32'd3, n);
      expect_rsp("sub ok", n + 5, RSP_OK, 2'd3, 32'd1);

      // Shifts: only op2[27:31] counts, so 0x24 shifts by 4.
      send(CMD_SHL, 2'd1, 32'h0000_0001, 32'h0000_0024, n);
      expect_rsp("shl", n + 5, SH_ON ? RSP_OK : RSP_ERR, 2'd1, SH_ON ? 32'h0000_0010 : 32'd0);
      send(CMD_SHR, 2'd2, 32'h8000_0000, 32'd31, n);
      expect_rsp("shr", n + 5, SH_ON ? RSP_OK : RSP_ERR, 2'd2, SH_ON ? 32'd1 : 32'd0);

      // Invalid command, then a request right behind it. The second is
      // popped only after the first response, so it answers at n2+7.
      send(4'hF, 2'd3, 32'h0000_1234, 32'h0000_5678, n);
      send(CMD_ADD, 2'd0, 32'd10, 32'd20, n2);
      expect_rsp("invalid", n + 5, RSP_ERR, 2'd3, 32'd0);
      expect_rsp("after inv", n2 + 7, RSP_OK, 2'd0, 32'd30);
      idle(4);

      // Sustained overrun: requests every 2 cycles, pops every 4. The queue
      // first meets a full state at request 8, which is dropped; request 9
      // arrives after the next pop and is accepted.
      for (int k = 0; k < 10; k++) begin
         send(CMD_ADD, k[1:0], k, 32'd100, s[k]);
      end
      check_eq("overrun drop_cnt", 32'(drop_cnt), 32'd1);
      for (int j = 0; j < 9; j++) begin
         int k;
         k = (j < 8) ? j : 9;
         expect_rsp($sformatf("overrun %0d", j), s[0] + 5 + 4 * j, RSP_OK, k[1:0], 32'(100 + k));
      end
      idle(12);
      check_eq("overrun extra rsp", 32'(rsp_q.size()), 32'd0);

      // Reset while BUSY with two entries queued.
      send(CMD_ADD, 2'd0, 32'd1, 32'd1, n);
      send(CMD_ADD, 2'd1, 32'd2, 32'd1, n2);
      send(CMD_ADD, 2'd2, 32'd3, 32'd1, n2);
      send(CMD_ADD, 2'd3, 32'd4, 32'd1, n2);
      reset = 1'b0;
      idle(1);
      check_eq("mid reset out_resp", 32'(out_resp), 32'd0);
      check_eq("mid reset out_data", out_data, 32'd0);
      check_eq("mid reset out_tag", 32'(out_tag), 32'd0);
      check_eq("mid reset drop_cnt", 32'(drop_cnt), 32'd0);
      reset = 1'b1;
      expect_rsp("pre reset", n + 5, RSP_OK, 2'd0, 32'd2);
      idle(20);
      check_eq("post reset silent", 32'(rsp_q.size()), 32'd0);
      send(CMD_ADD, 2'd1, 32'h0000_0100, 32'h0000_0023, n);
      expect_rsp("fresh", n + 5, RSP_OK, 2'd1, 32'h0000_0123);

      idle(4);
      check_eq("quiet outputs", quiet_bad, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
